// File: rtl/add_serial_arb.sv
// Round-robin arbiter/sequencer sharing one bit-serial adder among NREQ clients.
// One add in flight at a time; a WAIT-state timeout returns an error response.
module add_serial_arb #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    rsp_err,
    output logic                    add_en,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    input  logic                    add_done,
    input  logic [WIDTH-1:0]        add_sum
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_gnt;
    logic [PW-1:0]      w_pick;
    logic               w_found;
    logic               w_tmo;
    logic [7:0]         r_tcnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_rsp_data;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [NREQ-1:0]    r_rsp_valid;
    logic               r_rsp_err;
    logic               r_add_en;

    // Scan from the farthest offset down so the requester nearest ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_pick  = PW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_sel_a = req_a[int'(w_pick)*WIDTH +: WIDTH];
    assign w_sel_b = req_b[int'(w_pick)*WIDTH +: WIDTH];
    assign w_tmo   = (r_tcnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (add_done || w_tmo) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The accept strobe is the only combinational output; it is held low during reset.
    always_comb begin
        req_ready = '0;
        if (r_state == S_IDLE && w_found && !rst)
            req_ready = NREQ'(1) << w_pick;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_tcnt      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_add_en    <= 1'b0;
        end else begin
            r_add_en    <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_a      <= w_sel_a;
                        r_b      <= w_sel_b;
                        r_gnt    <= w_pick;
                        r_add_en <= 1'b1;
                    end
                end
                S_ISSUE: r_tcnt <= '0;
                S_WAIT: begin
                    // done takes priority over a coincident timeout
                    if (add_done) begin
                        r_rsp_valid <= NREQ'(1) << r_gnt;
                        r_rsp_data  <= add_sum;
                    end else if (w_tmo) begin
                        r_rsp_valid <= NREQ'(1) << r_gnt;
                        r_rsp_err   <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                S_RESP: r_ptr <= (r_gnt == PW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign add_en    = r_add_en;
    assign add_a     = r_a;
    assign add_b     = r_b;
endmodule

// File: tb/tb_add_serial_arb.sv
// Bench for add_serial_arb: directed vectors, multi-cycle corner sequences and
// randomized traffic against a transaction-level round-robin model.
module tb_add_serial_arb;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 15;
    localparam int LAT     = 11;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;
    logic                  add_en;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_done;
    logic [WIDTH-1:0]      add_sum;

    always #5 clk = ~clk;

    add_serial_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .add_en(add_en), .add_a(add_a), .add_b(add_b),
        .add_done(add_done), .add_sum(add_sum)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [NREQ-1:0]  s_ready, s_rspv;
    logic [WIDTH-1:0] s_data, s_a, s_b;
    logic             s_err, s_en;

    // adder model state
    int cd = 0;
    bit armed = 0;
    bit no_done = 0;
    bit force_done = 0;

    typedef struct {
        int               r;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
    } vec_t;
    vec_t tv[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Snapshot this cycle's outputs, advance one clock, then drive the adder model.
    task automatic tick();
        #1;
        s_ready = req_ready; s_rspv = rsp_valid; s_data = rsp_data; s_err = rsp_err;
        s_en = add_en; s_a = add_a; s_b = add_b;
        if (rst) armed = 0;
        else if (s_en && !no_done) begin armed = 1; cd = 9; end
        @(posedge clk);
        #1;
        cyc++;
        add_done = 1'b0;
        if (armed) begin
            cd--;
            if (cd == 0) begin
                armed = 0;
                add_done = 1'b1;
                add_sum = add_a + add_b;
            end
        end
        if (force_done) begin add_done = 1'b1; force_done = 0; end
    endtask

    task automatic set_ops(input int r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[r*WIDTH +: WIDTH] = a;
        req_b[r*WIDTH +: WIDTH] = b;
    endtask

    // Wait for requester r to be accepted, then follow it to its response.
    task automatic serve(input int r, input logic [WIDTH-1:0] exp, input int lat,
                         input bit err, input bit stray, input string tag);
        bit got;
        int c0;
        if (stray) force_done = 1;
        got = 0;
        for (int t = 0; t < 30 && !got; t++) begin
            tick();
            if (s_ready != 0) got = 1;
        end
        chk({tag, " ready"}, 32'(s_ready), 32'(1 << r));
        req_valid[r] = 1'b0;
        c0 = cyc - 1;
        tick();
        chk({tag, " add_en"}, 32'(s_en), 32'd1);
        chk({tag, " add_a"}, 32'(s_a), 32'(req_a[r*WIDTH +: WIDTH]));
        chk({tag, " add_b"}, 32'(s_b), 32'(req_b[r*WIDTH +: WIDTH]));
        got = 0;
        for (int t = 0; t < 40 && !got; t++) begin
            tick();
            if (s_rspv != 0) got = 1;
        end
        chk({tag, " rsp_valid"}, 32'(s_rspv), 32'(1 << r));
        chk({tag, " rsp_data"}, 32'(s_data), 32'(exp));
        chk({tag, " rsp_err"}, 32'(s_err), 32'(err));
        chk({tag, " latency"}, 32'(cyc - 1 - c0), 32'(lat));
    endtask

    task automatic run_single(input int r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [WIDTH-1:0] exp, input int lat, input bit err,
                              input bit stray, input string tag);
        set_ops(r, a, b);
        req_valid = NREQ'(1) << r;
        serve(r, exp, lat, err, stray, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord[5];
        int ng, nr;
        logic [NREQ-1:0] acc;
        logic [NREQ-1:0] pend;
        logic [WIDTH-1:0] ma[NREQ];
        logic [WIDTH-1:0] mb[NREQ];
        int since[NREQ];
        int mptr, cur, acc_cyc, w, maxw;
        bit busy;
        logic [WIDTH-1:0] esum;

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        add_done = 1'b0; add_sum = '0;
        tick();

        // Reset values, with every requester already valid
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_ops(i, 8'(16*i + 1), 8'(i + 2));
        tick();
        chk("reset req_ready", 32'(s_ready), 32'd0);
        chk("reset rsp_valid", 32'(s_rspv), 32'd0);
        chk("reset rsp_data", 32'(s_data), 32'd0);
        chk("reset rsp_err", 32'(s_err), 32'd0);
        chk("reset add_en", 32'(s_en), 32'd0);
        chk("reset add_a", 32'(s_a), 32'd0);
        chk("reset add_b", 32'(s_b), 32'd0);

        // All requesters held valid from reset: grant order 0,1,2,3,0
        ord = '{0, 1, 2, 3, 0};
        rst = 1'b0;
        ng = 0; nr = 0;
        for (int t = 0; t < 120 && nr < 5; t++) begin
            tick();
            if (s_ready != 0) begin
                if (ng < 5) chk($sformatf("order grant%0d", ng), 32'(s_ready), 32'(1 << ord[ng]));
                ng++;
                if (ng == 5) req_valid = '0;
            end
            if (s_rspv != 0) begin
                if (nr < 5) begin
                    chk($sformatf("order rsp%0d", nr), 32'(s_rspv), 32'(1 << ord[nr]));
                    chk($sformatf("order data%0d", nr), 32'(s_data),
                        32'(8'(16*ord[nr] + 1) + 8'(ord[nr] + 2)));
                end
                nr++;
            end
        end
        chk("order responses", 32'(nr), 32'd5);

        // Directed single-request vectors
        tv[0] = '{2, 8'h3C, 8'h05, 8'h41};
        tv[1] = '{0, 8'hFF, 8'h01, 8'h00};
        tv[2] = '{1, 8'h80, 8'h80, 8'h00};
        tv[3] = '{3, 8'h12, 8'h34, 8'h46};
        tv[4] = '{2, 8'hA5, 8'h5A, 8'hFF};
        for (int i = 0; i < 5; i++)
            run_single(tv[i].r, tv[i].a, tv[i].b, tv[i].s, LAT, 1'b0, 1'b0, $sformatf("vec%0d", i));

        // Timeout, then the next requester is served normally
        no_done = 1;
        run_single(1, 8'h11, 8'h22, 8'h00, TIMEOUT + 2, 1'b1, 1'b0, "timeout");
        no_done = 0;
        run_single(2, 8'h21, 8'h43, 8'h64, LAT, 1'b0, 1'b0, "after_timeout");

        // Stray add_done while idle, then during ISSUE
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            force_done = 1;
            tick();
            acc = acc | s_rspv | NREQ'(s_en);
        end
        tick();
        acc = acc | s_rspv | NREQ'(s_en);
        chk("stray idle activity", 32'(acc), 32'd0);
        run_single(1, 8'h07, 8'h09, 8'h10, LAT, 1'b0, 1'b1, "stray_issue");

        // Reset mid-WAIT: aborted request never answers, pending ones restart from ptr 0
        run_single(1, 8'h01, 8'h01, 8'h02, LAT, 1'b0, 1'b0, "pre_rst");
        set_ops(3, 8'h5A, 8'hA7);
        req_valid = 4'b1000;
        tick();
        chk("rst accept3", 32'(s_ready), 32'b1000);
        set_ops(0, 8'h30, 8'h03);
        set_ops(2, 8'h40, 8'h04);
        req_valid = 4'b0101;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        chk("rst mid rsp_valid", 32'(s_rspv), 32'd0);
        chk("rst mid add_en", 32'(s_en), 32'd0);
        chk("rst mid add_a", 32'(s_a), 32'd0);
        chk("rst mid add_b", 32'(s_b), 32'd0);
        chk("rst mid rsp_data", 32'(s_data), 32'd0);
        chk("rst mid rsp_err", 32'(s_err), 32'd0);
        chk("rst mid req_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        serve(0, 8'h33, LAT, 1'b0, 1'b0, "post_rst0");
        serve(2, 8'h44, LAT, 1'b0, 1'b0, "post_rst2");

        // Randomized traffic against a transaction-level model
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pend = '0; mptr = 0; busy = 0; cur = 0; acc_cyc = 0; maxw = 0; esum = '0;
        for (int i = 0; i < NREQ; i++) begin ma[i] = '0; mb[i] = '0; since[i] = 0; end
        for (int n = 0; n < 2500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(3) == 0) begin
                    pend[i] = 1'b1;
                    ma[i] = 8'($urandom);
                    mb[i] = 8'($urandom);
                    since[i] = 0;
                end
                set_ops(i, ma[i], mb[i]);
            end
            req_valid = pend;
            tick();
            w = -1;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && pend[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
            if (busy) begin
                if (s_ready != 0) chk("rand busy accept", 32'(s_ready), 32'd0);
            end else if (w >= 0 || s_ready != 0) begin
                chk("rand grant", 32'(s_ready), (w < 0) ? 32'd0 : 32'(1 << w));
                if (w >= 0) begin
                    busy = 1; cur = w; acc_cyc = cyc - 1;
                    esum = ma[w] + mb[w];
                    pend[w] = 1'b0;
                    if (since[w] > maxw) maxw = since[w];
                end
            end
            if (busy && (cyc - 1 - acc_cyc) == LAT) begin
                chk("rand rsp_valid", 32'(s_rspv), 32'(1 << cur));
                chk("rand rsp_data", 32'(s_data), 32'(esum));
                chk("rand rsp_err", 32'(s_err), 32'd0);
                busy = 0;
                mptr = (cur + 1) % NREQ;
            end else if (s_rspv != 0) begin
                chk("rand unexpected rsp", 32'(s_rspv), 32'd0);
            end
            for (int i = 0; i < NREQ; i++) if (pend[i]) since[i]++;
        end
        chk("rand fairness wait bound", 32'(maxw > NREQ*12), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
